// File: rtl/control_unit_pkg.sv
// Shared definitions for the hardwired sequencer: opcodes, datapath function
// codes, mux sources, address-register indices and the bundled control word.
package control_unit_pkg;

  // Width of the one-hot T counter, i.e. the longest micro-sequence.
  localparam int T_STATES = 8;
  localparam logic [T_STATES-1:0] T0_ONEHOT = T_STATES'(1);

  typedef enum logic [5:0] {
    OP_BRA = 6'h00,
    OP_BNE = 6'h01,
    OP_BEQ = 6'h02,
    OP_ADD = 6'h04,
    OP_SUB = 6'h05,
    OP_LD  = 6'h06,
    OP_ST  = 6'h07,
    OP_HLT = 6'h3F
  } opcode_t;

  typedef enum logic [4:0] {
    ALU_PASS_A = 5'b00000,
    ALU_ADD    = 5'b00100,
    ALU_SUB    = 5'b00110
  } alu_fun_t;

  typedef enum logic [2:0] {
    RF_DEC  = 3'b000,
    RF_INC  = 3'b001,
    RF_LOAD = 3'b010,
    RF_CLR  = 3'b011
  } rf_fun_t;

  typedef enum logic [1:0] {ARF_DEC, ARF_INC, ARF_LOAD, ARF_CLR} arf_fun_t;
  typedef enum logic [1:0] {DR_CLR, DR_LOAD, DR_SHL, DR_SHR} dr_fun_t;

  // Sources shared by MuxA/MuxB/MuxC.
  typedef enum logic [1:0] {MUX_ALU, MUX_ARFC, MUX_DR, MUX_IR} mux_src_t;

  // Address register file read ports.
  typedef enum logic [1:0] {ARF_PC, ARF_AR, ARF_SP} arf_idx_t;

  // Register enables are active-low; all-ones means every register holds.
  localparam logic [3:0] RF_EN_NONE  = 4'b1111;
  localparam logic [2:0] ARF_EN_NONE = 3'b111;
  localparam logic [2:0] ARF_EN_PC   = 3'b011;  // enable bits are {PC,AR,SP}

  // Every select/enable driven into the datapath, bundled so a single
  // default assignment covers all of them.
  typedef struct packed {
    logic [1:0] mux_a, mux_b, mux_c;
    logic       mux_d;
    logic [3:0] rf_reg, rf_scr;
    logic [2:0] rf_fun, rf_out_a, rf_out_b;
    logic [4:0] alu_fun;
    logic [2:0] arf_reg;
    logic [1:0] arf_fun, arf_out_c, arf_out_d;
    logic       dr_en;
    logic [1:0] dr_fun;
    logic       mem_cs, mem_wr, ir_high, ir_write;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    mux_a: 2'b00, mux_b: 2'b00, mux_c: 2'b00, mux_d: 1'b0,
    rf_reg: RF_EN_NONE, rf_scr: RF_EN_NONE,
    rf_fun: 3'b000, rf_out_a: 3'b000, rf_out_b: 3'b000,
    alu_fun: 5'b00000,
    arf_reg: ARF_EN_NONE, arf_fun: 2'b00, arf_out_c: 2'b00, arf_out_d: 2'b00,
    dr_en: 1'b0, dr_fun: 2'b00,
    mem_cs: 1'b1, mem_wr: 1'b0, ir_high: 1'b0, ir_write: 1'b0
  };

  // Active-low write enable selecting general register Rn.
  function automatic logic [3:0] rf_en(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/control_unit_sequence_counter.sv
// One-hot T-state register. Advances one step per cycle, returns to T0 on
// step_end (or on overrun past the last state), and freezes permanently
// once a halt is requested until the next reset.
module sequence_counter
  import control_unit_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                step_end,
  input  logic                freeze,
  output logic [T_STATES-1:0] t,
  output logic                halted
);

  // Advance, wrap or hold the T-state; halt is sticky until reset.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      t      <= T0_ONEHOT;
      halted <= 1'b0;
    end else if (halted || freeze) begin
      halted <= 1'b1;
    end else if (step_end || t[T_STATES-1] || !$onehot(t)) begin
      t <= T0_ONEHOT;
    end else begin
      t <= t << 1;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired sequencer for alu_system: two-byte fetch, decode of IROut and one
// micro-op per cycle. All datapath controls are a combinational function of
// the T-state, IROut and the Z flag.
module control_unit
  import control_unit_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [15:0]         IROut,
  input  logic [3:0]          FlagOut,
  output logic [1:0]          MuxASel,
  output logic [1:0]          MuxBSel,
  output logic [1:0]          MuxCSel,
  output logic                MuxDSel,
  output logic [3:0]          RFRegSel,
  output logic [3:0]          RFScrSel,
  output logic [2:0]          RFFunSel,
  output logic [2:0]          RFOutASel,
  output logic [2:0]          RFOutBSel,
  output logic [4:0]          ALUFunSel,
  output logic [2:0]          ARFRegSel,
  output logic [1:0]          ARFFunSel,
  output logic [1:0]          ARFOutCSel,
  output logic [1:0]          ARFOutDSel,
  output logic                DREnable,
  output logic [1:0]          DRFunSel,
  output logic                MemCS,
  output logic                MemWR,
  output logic                IRHighSel,
  output logic                IRWrite,
  output logic [T_STATES-1:0] T,
  output logic                Halted
);

  opcode_t    opc;
  logic [1:0] dst, s1, s2;
  logic       flag_z;
  logic       step_end, freeze, take_branch;
  ctrl_t      c;

  assign opc    = opcode_t'(IROut[15:10]);
  assign dst    = IROut[5:4];
  assign s1     = IROut[3:2];
  assign s2     = IROut[1:0];
  assign flag_z = FlagOut[3];

  // The immediate byte reaches the datapath through MuxB, and only Z steers
  // branches, so these bits are deliberately ignored here.
  logic unused_bits;
  assign unused_bits = ^{IROut[9:6], FlagOut[2:0]};

  sequence_counter u_seq (
    .clock    (clock),
    .reset    (reset),
    .step_end (step_end),
    .freeze   (freeze),
    .t        (T),
    .halted   (Halted)
  );

  // Decode T-state and instruction into one control word per cycle.
  // NOTE: every signal written here gets its default first, so no path
  // through the branches below can infer a latch.
  always_comb begin
    c           = CTRL_IDLE;
    step_end    = 1'b0;
    freeze      = 1'b0;
    take_branch = 1'b0;

    // Nothing reaches the datapath while reset is held or after HLT.
    if (!reset && !Halted) begin
      if (T[0] || T[1]) begin
        // Fetch low then high byte from memory[PC], PC++ each time.
        c.arf_out_d = ARF_PC;
        c.mem_cs    = 1'b0;
        c.mem_wr    = 1'b0;
        c.ir_write  = 1'b1;
        c.ir_high   = T[1];
        c.arf_reg   = ARF_EN_PC;
        c.arf_fun   = ARF_INC;
      end else if (T[2]) begin
        step_end = 1'b1;
        unique case (opc)
          OP_BRA: take_branch = 1'b1;
          OP_BNE: take_branch = !flag_z;
          OP_BEQ: take_branch = flag_z;
          OP_ADD, OP_SUB: begin
            c.rf_out_a = {1'b0, s1};
            c.rf_out_b = {1'b0, s2};
            c.mux_d    = 1'b0;
            c.alu_fun  = (opc == OP_ADD) ? ALU_ADD : ALU_SUB;
            c.mux_a    = MUX_ALU;
            c.rf_fun   = RF_LOAD;
            c.rf_reg   = rf_en(dst);
          end
          OP_LD: begin
            // Memory[AR] into DR now; DR into Rdst on T3.
            step_end    = 1'b0;
            c.arf_out_d = ARF_AR;
            c.mem_cs    = 1'b0;
            c.dr_en     = 1'b1;
            c.dr_fun    = DR_LOAD;
          end
          OP_ST: begin
            c.rf_out_a  = {1'b0, s1};
            c.mux_d     = 1'b0;
            c.alu_fun   = ALU_PASS_A;
            c.mux_c     = MUX_ALU;
            c.arf_out_d = ARF_AR;
            c.mem_cs    = 1'b0;
            c.mem_wr    = 1'b1;
          end
          OP_HLT: begin
            step_end = 1'b0;
            freeze   = 1'b1;
          end
          default: ;  // undefined opcode: one idle step, then fetch
        endcase
        if (take_branch) begin
          c.mux_b   = MUX_IR;
          c.arf_reg = ARF_EN_PC;
          c.arf_fun = ARF_LOAD;
        end
      end else begin
        // Only LD reaches T3; any later state just restarts the fetch.
        step_end = 1'b1;
        if (T[3] && opc == OP_LD) begin
          c.mux_a  = MUX_DR;
          c.rf_fun = RF_LOAD;
          c.rf_reg = rf_en(dst);
        end
      end
    end
  end

  assign MuxASel    = c.mux_a;
  assign MuxBSel    = c.mux_b;
  assign MuxCSel    = c.mux_c;
  assign MuxDSel    = c.mux_d;
  assign RFRegSel   = c.rf_reg;
  assign RFScrSel   = c.rf_scr;
  assign RFFunSel   = c.rf_fun;
  assign RFOutASel  = c.rf_out_a;
  assign RFOutBSel  = c.rf_out_b;
  assign ALUFunSel  = c.alu_fun;
  assign ARFRegSel  = c.arf_reg;
  assign ARFFunSel  = c.arf_fun;
  assign ARFOutCSel = c.arf_out_c;
  assign ARFOutDSel = c.arf_out_d;
  assign DREnable   = c.dr_en;
  assign DRFunSel   = c.dr_fun;
  assign MemCS      = c.mem_cs;
  assign MemWR      = c.mem_wr;
  assign IRHighSel  = c.ir_high;
  assign IRWrite    = c.ir_write;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed walk through fetch, branch, ALU, load,
// halt and reset cases, then randomized instruction streams with random
// flags and resets, every cycle compared against an instruction-level model.
module tb_control_unit;
  import control_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] IROut;
  logic [3:0]  FlagOut;
  logic [1:0]  MuxASel, MuxBSel, MuxCSel;
  logic        MuxDSel;
  logic [3:0]  RFRegSel, RFScrSel;
  logic [2:0]  RFFunSel, RFOutASel, RFOutBSel;
  logic [4:0]  ALUFunSel;
  logic [2:0]  ARFRegSel;
  logic [1:0]  ARFFunSel, ARFOutCSel, ARFOutDSel;
  logic        DREnable;
  logic [1:0]  DRFunSel;
  logic        MemCS, MemWR, IRHighSel, IRWrite;
  logic [7:0]  T;
  logic        Halted;

  control_unit dut (
    .clock(clock), .reset(reset), .IROut(IROut), .FlagOut(FlagOut),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .MuxDSel(MuxDSel),
    .RFRegSel(RFRegSel), .RFScrSel(RFScrSel), .RFFunSel(RFFunSel),
    .RFOutASel(RFOutASel), .RFOutBSel(RFOutBSel), .ALUFunSel(ALUFunSel),
    .ARFRegSel(ARFRegSel), .ARFFunSel(ARFFunSel), .ARFOutCSel(ARFOutCSel),
    .ARFOutDSel(ARFOutDSel), .DREnable(DREnable), .DRFunSel(DRFunSel),
    .MemCS(MemCS), .MemWR(MemWR), .IRHighSel(IRHighSel), .IRWrite(IRWrite),
    .T(T), .Halted(Halted)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: position within the current instruction and halt flag.
  int m_step   = 0;
  bit m_halted = 1'b0;

  typedef struct {
    logic [1:0] mux_a, mux_b, mux_c;
    logic       mux_d;
    logic [3:0] rf_reg, rf_scr;
    logic [2:0] rf_fun, rf_out_a, rf_out_b;
    logic [4:0] alu_fun;
    logic [2:0] arf_reg;
    logic [1:0] arf_fun, arf_out_c, arf_out_d;
    logic       dr_en;
    logic [1:0] dr_fun;
    logic       mem_cs, mem_wr, ir_high, ir_write;
  } exp_t;

  function automatic exp_t expect_ctrl(input int st, input bit hlt, input logic rst,
                                       input logic [15:0] ir, input logic z);
    exp_t e;
    logic [5:0] op;
    logic [1:0] d;
    op = ir[15:10];
    d  = ir[5:4];
    e.mux_a = 2'b00; e.mux_b = 2'b00; e.mux_c = 2'b00; e.mux_d = 1'b0;
    e.rf_reg = 4'b1111; e.rf_scr = 4'b1111; e.rf_fun = 3'b000;
    e.rf_out_a = 3'b000; e.rf_out_b = 3'b000; e.alu_fun = 5'b00000;
    e.arf_reg = 3'b111; e.arf_fun = 2'b00; e.arf_out_c = 2'b00; e.arf_out_d = 2'b00;
    e.dr_en = 1'b0; e.dr_fun = 2'b00;
    e.mem_cs = 1'b1; e.mem_wr = 1'b0; e.ir_high = 1'b0; e.ir_write = 1'b0;
    if (rst || hlt) return e;
    if (st < 2) begin
      e.arf_out_d = 2'b00; e.mem_cs = 1'b0; e.ir_write = 1'b1;
      e.ir_high = (st == 1); e.arf_reg = 3'b011; e.arf_fun = ARF_INC;
    end else if (st == 2) begin
      if (op == OP_BRA || (op == OP_BNE && !z) || (op == OP_BEQ && z)) begin
        e.mux_b = 2'b11; e.arf_reg = 3'b011; e.arf_fun = ARF_LOAD;
      end else if (op == OP_ADD || op == OP_SUB) begin
        e.rf_out_a = {1'b0, ir[3:2]}; e.rf_out_b = {1'b0, ir[1:0]};
        e.alu_fun = (op == OP_ADD) ? ALU_ADD : ALU_SUB;
        e.rf_fun = RF_LOAD; e.rf_reg = 4'b1111 ^ (4'b0001 << d);
      end else if (op == OP_LD) begin
        e.arf_out_d = 2'b01; e.mem_cs = 1'b0; e.dr_en = 1'b1; e.dr_fun = DR_LOAD;
      end else if (op == OP_ST) begin
        e.rf_out_a = {1'b0, ir[3:2]}; e.alu_fun = ALU_PASS_A;
        e.arf_out_d = 2'b01; e.mem_cs = 1'b0; e.mem_wr = 1'b1;
      end
    end else if (st == 3 && op == OP_LD) begin
      e.mux_a = 2'b10; e.rf_fun = RF_LOAD; e.rf_reg = 4'b1111 ^ (4'b0001 << d);
    end
    return e;
  endfunction

  task automatic compare_all();
    exp_t e;
    e = expect_ctrl(m_step, m_halted, reset, IROut, FlagOut[3]);
    check("T", T, 8'(1 << m_step));
    check("Halted", Halted, m_halted);
    check("MuxASel", MuxASel, e.mux_a);
    check("MuxBSel", MuxBSel, e.mux_b);
    check("MuxCSel", MuxCSel, e.mux_c);
    check("MuxDSel", MuxDSel, e.mux_d);
    check("RFRegSel", RFRegSel, e.rf_reg);
    check("RFScrSel", RFScrSel, e.rf_scr);
    check("RFFunSel", RFFunSel, e.rf_fun);
    check("RFOutASel", RFOutASel, e.rf_out_a);
    check("RFOutBSel", RFOutBSel, e.rf_out_b);
    check("ALUFunSel", ALUFunSel, e.alu_fun);
    check("ARFRegSel", ARFRegSel, e.arf_reg);
    check("ARFFunSel", ARFFunSel, e.arf_fun);
    check("ARFOutCSel", ARFOutCSel, e.arf_out_c);
    check("ARFOutDSel", ARFOutDSel, e.arf_out_d);
    check("DREnable", DREnable, e.dr_en);
    check("DRFunSel", DRFunSel, e.dr_fun);
    check("MemCS", MemCS, e.mem_cs);
    check("MemWR", MemWR, e.mem_wr);
    check("IRHighSel", IRHighSel, e.ir_high);
    check("IRWrite", IRWrite, e.ir_write);
  endtask

  // Instruction lengths: LD takes 4 steps, HLT never ends, the rest take 3.
  task automatic model_update();
    if (reset) begin
      m_step   = 0;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      if (m_step == 2 && IROut[15:10] == OP_HLT) m_halted = 1'b1;
      else if (m_step >= 2 && m_step >= ((IROut[15:10] == OP_LD) ? 3 : 2)) m_step = 0;
      else m_step++;
    end
  endtask

  task automatic drive_check(input logic r, input logic [15:0] ir, input logic [3:0] fl);
    reset   = r;
    IROut   = ir;
    FlagOut = fl;
    @(negedge clock);
    compare_all();
  endtask

  task automatic advance();
    @(posedge clock);
    model_update();
    #1;
  endtask

  // Runs T0 and T1 and leaves the bench sampled at T2.
  task automatic fetch_to_t2(input string tag, input logic [15:0] ir, input logic [3:0] fl);
    drive_check(1'b0, ir, fl); check({tag, "_T0"}, T, 8'h01); advance();
    drive_check(1'b0, ir, fl); check({tag, "_T1"}, T, 8'h02); advance();
    drive_check(1'b0, ir, fl); check({tag, "_T2"}, T, 8'h04);
  endtask

  function automatic logic [15:0] mk(input logic [5:0] op, input logic [1:0] d,
                                     input logic [1:0] a, input logic [1:0] b);
    return {op, 4'b0000, d, a, b};
  endfunction

  function automatic logic [15:0] rand_instr();
    logic [5:0] op;
    int k;
    k = $urandom_range(0, 19);
    case (k)
      0, 1:      op = OP_BRA;
      2, 3:      op = OP_BNE;
      4, 5:      op = OP_BEQ;
      6, 7:      op = OP_ADD;
      8, 9:      op = OP_SUB;
      10, 11, 12: op = OP_LD;
      13, 14:    op = OP_ST;
      15:        op = OP_HLT;
      default: begin
        do op = 6'($urandom);
        while (op inside {OP_BRA, OP_BNE, OP_BEQ, OP_ADD, OP_SUB, OP_LD, OP_ST, OP_HLT});
      end
    endcase
    return {op, 10'($urandom)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        r;
    logic [15:0] ir, cur_ir;
    int          rst_left, halt_wait;
    bit          was_halted;

    reset = 1'b1; IROut = 16'h0000; FlagOut = 4'h0;
    repeat (2) @(posedge clock);
    #1;
    m_step = 0; m_halted = 1'b0;

    // Release from reset straight into fetch-lo, then BRA 0x42.
    drive_check(1'b0, 16'h0042, 4'h0);
    check("rst_T", T, 8'h01);
    check("rst_MemCS", MemCS, 1'b0);
    check("rst_IRWrite", IRWrite, 1'b1);
    check("rst_IRHighSel", IRHighSel, 1'b0);
    check("rst_ARFRegSel", ARFRegSel, 3'b011);
    check("rst_ARFFunSel", ARFFunSel, ARF_INC);
    advance();
    drive_check(1'b0, 16'h0042, 4'h0);
    check("t1_IRHighSel", IRHighSel, 1'b1);
    advance();
    drive_check(1'b0, 16'h0042, 4'h0);
    check("bra_MuxBSel", MuxBSel, 2'b11);
    check("bra_ARFRegSel", ARFRegSel, 3'b011);
    check("bra_ARFFunSel", ARFFunSel, ARF_LOAD);
    advance();

    fetch_to_t2("beq_z1", mk(OP_BEQ, 2'd0, 2'd0, 2'd0), 4'b1000);
    check("beq_z1_ARFRegSel", ARFRegSel, 3'b011);
    advance();
    fetch_to_t2("beq_z0", mk(OP_BEQ, 2'd0, 2'd0, 2'd0), 4'b0000);
    check("beq_z0_ARFRegSel", ARFRegSel, 3'b111);
    advance();

    fetch_to_t2("add", mk(OP_ADD, 2'd2, 2'd0, 2'd1), 4'h0);
    check("add_RFOutASel", RFOutASel, 3'd0);
    check("add_RFOutBSel", RFOutBSel, 3'd1);
    check("add_ALUFunSel", ALUFunSel, ALU_ADD);
    check("add_RFRegSel", RFRegSel, 4'b1011);
    advance();

    fetch_to_t2("ld", mk(OP_LD, 2'd3, 2'd0, 2'd0), 4'h0);
    check("ld_DREnable", DREnable, 1'b1);
    check("ld_ARFOutDSel", ARFOutDSel, 2'b01);
    advance();
    drive_check(1'b0, mk(OP_LD, 2'd3, 2'd0, 2'd0), 4'h0);
    check("ld_T3", T, 8'h08);
    check("ld_MuxASel", MuxASel, 2'b10);
    check("ld_RFRegSel", RFRegSel, 4'b0111);
    advance();

    fetch_to_t2("hlt", {OP_HLT, 10'h000}, 4'h0);
    advance();
    for (int i = 0; i < 10; i++) begin
      drive_check(1'b0, {OP_HLT, 10'h000}, 4'($urandom));
      check("hlt_Halted", Halted, 1'b1);
      check("hlt_T", T, 8'h04);
      check("hlt_ARFRegSel", ARFRegSel, 3'b111);
      advance();
    end
    drive_check(1'b1, {OP_HLT, 10'h000}, 4'h0);
    advance();

    fetch_to_t2("post_hlt", mk(OP_LD, 2'd1, 2'd0, 2'd0), 4'h0);
    check("post_hlt_Halted", Halted, 1'b0);
    advance();
    drive_check(1'b1, mk(OP_LD, 2'd1, 2'd0, 2'd0), 4'h0);
    check("mid_rst_T3", T, 8'h08);
    advance();
    drive_check(1'b0, 16'h1234, 4'h0);
    check("mid_rst_T0", T, 8'h01);
    advance();

    // Randomized instruction stream with random flags, resets and halts.
    cur_ir = rand_instr(); rst_left = 0; halt_wait = 0;
    for (int i = 0; i < 3000 && n_err < 40; i++) begin
      if (rst_left > 0) begin
        r = 1'b1; rst_left--;
      end else if (m_halted) begin
        if (halt_wait == 0) begin
          r = 1'b1; rst_left = $urandom_range(0, 1);
        end else begin
          r = 1'b0; halt_wait--;
        end
      end else if ($urandom_range(0, 99) < 3) begin
        r = 1'b1; rst_left = $urandom_range(0, 1);
      end else begin
        r = 1'b0;
      end
      if (m_step == 0 && !m_halted) cur_ir = rand_instr();
      ir = (m_step >= 2 && !m_halted) ? cur_ir : 16'($urandom);
      was_halted = m_halted;
      drive_check(r, ir, 4'($urandom));
      advance();
      if (m_halted && !was_halted) halt_wait = $urandom_range(2, 12);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
